// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the ALU port of func_units.
//
// Dispatched micro-ops are held until their A, B and NZCV operands are all
// valid. Missing operands are captured from the result broadcast by ROB tag.
// While the ALU reports ready, the lowest-index ready entry is issued through
// registered out_fu_* outputs. out_fu_start is a one-cycle strobe.
//
// Compile-time option:
//   RS_CDB_BYPASS_EN - when defined, select also treats a same-cycle matching
//                      broadcast as ready and forwards its value into the
//                      issue registers (broadcast -> start in 1 cycle instead
//                      of 2).
//
// Ports:
//   in_clk, in_rst            clock, asynchronous active-high reset
//   in_dispatch_*             dispatch request, operands, tags, flags, dst
//   in_cdb_*                  result broadcast (tag, value, optional flags)
//   in_fu_ready               ALU can accept an op at the next edge
//   in_flush                  mispredict flush: drop every entry
//   out_dispatch_ready        at least one free entry
//   out_fu_start / out_fu_*   issue strobe and issued micro-op fields

package alu_rs_pkg;
    localparam int GPR_SIZE     = 32;
    localparam int ROB_IDX_SIZE = 4;

    typedef enum logic [3:0] {
        FU_PLUS  = 4'd0,
        FU_MINUS = 4'd1,
        FU_AND   = 4'd2,
        FU_ORR   = 4'd3,
        FU_EOR   = 4'd4,
        FU_LSL   = 4'd5,
        FU_LSR   = 4'd6,
        FU_CSEL  = 4'd7
    } fu_op_t;

    typedef logic [3:0] nzcv_t;
    typedef logic [3:0] cond_t;
endpackage

module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_ENTRIES = 4
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_dispatch_valid,
    input  fu_op_t                  in_dispatch_fu_op,
    input  logic [GPR_SIZE-1:0]     in_dispatch_val_a,
    input  logic [GPR_SIZE-1:0]     in_dispatch_val_b,
    input  logic                    in_dispatch_a_ready,
    input  logic                    in_dispatch_b_ready,
    input  logic [ROB_IDX_SIZE-1:0] in_dispatch_a_rob_index,
    input  logic [ROB_IDX_SIZE-1:0] in_dispatch_b_rob_index,
    input  nzcv_t                   in_dispatch_nzcv,
    input  logic                    in_dispatch_nzcv_ready,
    input  logic [ROB_IDX_SIZE-1:0] in_dispatch_nzcv_rob_index,
    input  logic                    in_dispatch_set_nzcv,
    input  cond_t                   in_dispatch_cond,
    input  logic [ROB_IDX_SIZE-1:0] in_dispatch_dst_rob_index,
    input  logic                    in_cdb_done,
    input  logic [ROB_IDX_SIZE-1:0] in_cdb_rob_index,
    input  logic [GPR_SIZE-1:0]     in_cdb_value,
    input  logic                    in_cdb_set_nzcv,
    input  nzcv_t                   in_cdb_nzcv,
    input  logic                    in_fu_ready,
    input  logic                    in_flush,
    output logic                    out_dispatch_ready,
    output logic                    out_fu_start,
    output fu_op_t                  out_fu_op,
    output logic [GPR_SIZE-1:0]     out_fu_val_a,
    output logic [GPR_SIZE-1:0]     out_fu_val_b,
    output logic [ROB_IDX_SIZE-1:0] out_fu_dst_rob_index,
    output logic                    out_fu_set_nzcv,
    output nzcv_t                   out_fu_nzcv,
    output cond_t                   out_fu_cond
);

    localparam int IDX_W = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;

    logic [RS_ENTRIES-1:0]   ent_vld;
    fu_op_t                  ent_op    [RS_ENTRIES];
    logic [GPR_SIZE-1:0]     ent_a_val [RS_ENTRIES];
    logic [GPR_SIZE-1:0]     ent_b_val [RS_ENTRIES];
    nzcv_t                   ent_f_val [RS_ENTRIES];
    logic [RS_ENTRIES-1:0]   ent_a_rdy;
    logic [RS_ENTRIES-1:0]   ent_b_rdy;
    logic [RS_ENTRIES-1:0]   ent_f_rdy;
    logic [ROB_IDX_SIZE-1:0] ent_a_tag [RS_ENTRIES];
    logic [ROB_IDX_SIZE-1:0] ent_b_tag [RS_ENTRIES];
    logic [ROB_IDX_SIZE-1:0] ent_f_tag [RS_ENTRIES];
    logic [RS_ENTRIES-1:0]   ent_set_nzcv;
    cond_t                   ent_cond  [RS_ENTRIES];
    logic [ROB_IDX_SIZE-1:0] ent_dst   [RS_ENTRIES];

    logic [RS_ENTRIES-1:0]   wk_a, wk_b, wk_f, rdy_eff;
    logic [GPR_SIZE-1:0]     a_eff [RS_ENTRIES];
    logic [GPR_SIZE-1:0]     b_eff [RS_ENTRIES];
    nzcv_t                   f_eff [RS_ENTRIES];

    logic                    sel_found, free_found;
    logic [IDX_W-1:0]        sel_idx, free_idx;
    logic                    issue_go, disp_go;

    logic                    disp_a_rdy, disp_b_rdy, disp_f_rdy;
    logic [GPR_SIZE-1:0]     disp_a_val, disp_b_val;
    nzcv_t                   disp_f_val;

    // Full exactly when every valid bit is set, i.e. registered count == RS_ENTRIES.
    assign out_dispatch_ready = ~(&ent_vld);

    // Wakeup match per entry; the NZCV operand only wakes on flag-carrying broadcasts.
    always_comb begin
        for (int i = 0; i < RS_ENTRIES; i++) begin
            wk_a[i] = in_cdb_done && !ent_a_rdy[i] && (ent_a_tag[i] == in_cdb_rob_index);
            wk_b[i] = in_cdb_done && !ent_b_rdy[i] && (ent_b_tag[i] == in_cdb_rob_index);
            wk_f[i] = in_cdb_done && in_cdb_set_nzcv && !ent_f_rdy[i]
                      && (ent_f_tag[i] == in_cdb_rob_index);
`ifdef RS_CDB_BYPASS_EN
            rdy_eff[i] = ent_vld[i] && (ent_a_rdy[i] || wk_a[i])
                         && (ent_b_rdy[i] || wk_b[i]) && (ent_f_rdy[i] || wk_f[i]);
            a_eff[i]   = wk_a[i] ? in_cdb_value : ent_a_val[i];
            b_eff[i]   = wk_b[i] ? in_cdb_value : ent_b_val[i];
            f_eff[i]   = wk_f[i] ? in_cdb_nzcv  : ent_f_val[i];
`else
            rdy_eff[i] = ent_vld[i] && ent_a_rdy[i] && ent_b_rdy[i] && ent_f_rdy[i];
            a_eff[i]   = ent_a_val[i];
            b_eff[i]   = ent_b_val[i];
            f_eff[i]   = ent_f_val[i];
`endif
        end
    end

    // Lowest-index ready entry for issue, lowest-index free entry for dispatch.
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (!sel_found && rdy_eff[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!free_found && !ent_vld[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign issue_go = in_fu_ready && sel_found && !in_flush;
    assign disp_go  = in_dispatch_valid && out_dispatch_ready && !in_flush;

    // Dispatch-time capture covers a broadcast landing in the same cycle.
    always_comb begin
        disp_a_rdy = in_dispatch_a_ready
                     || (in_cdb_done && (in_dispatch_a_rob_index == in_cdb_rob_index));
        disp_b_rdy = in_dispatch_b_ready
                     || (in_cdb_done && (in_dispatch_b_rob_index == in_cdb_rob_index));
        disp_f_rdy = in_dispatch_nzcv_ready
                     || (in_cdb_done && in_cdb_set_nzcv
                         && (in_dispatch_nzcv_rob_index == in_cdb_rob_index));
        disp_a_val = in_dispatch_a_ready    ? in_dispatch_val_a : in_cdb_value;
        disp_b_val = in_dispatch_b_ready    ? in_dispatch_val_b : in_cdb_value;
        disp_f_val = in_dispatch_nzcv_ready ? in_dispatch_nzcv  : in_cdb_nzcv;
    end

    // Control and issue registers: valid bits, start strobe, issued fields.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            ent_vld              <= '0;
            out_fu_start         <= 1'b0;
            out_fu_op            <= FU_PLUS;
            out_fu_val_a         <= '0;
            out_fu_val_b         <= '0;
            out_fu_dst_rob_index <= '0;
            out_fu_set_nzcv      <= 1'b0;
            out_fu_nzcv          <= '0;
            out_fu_cond          <= '0;
        end else if (in_flush) begin
            ent_vld      <= '0;
            out_fu_start <= 1'b0;
        end else begin
            out_fu_start <= issue_go;
            if (issue_go) begin
                ent_vld[sel_idx]     <= 1'b0;
                out_fu_op            <= ent_op[sel_idx];
                out_fu_val_a         <= a_eff[sel_idx];
                out_fu_val_b         <= b_eff[sel_idx];
                out_fu_dst_rob_index <= ent_dst[sel_idx];
                out_fu_set_nzcv      <= ent_set_nzcv[sel_idx];
                out_fu_nzcv          <= f_eff[sel_idx];
                out_fu_cond          <= ent_cond[sel_idx];
            end
            // The free slot is never the issuing one, so both writes can coexist.
            if (disp_go) begin
                ent_vld[free_idx] <= 1'b1;
            end
        end
    end

    // Entry payload: only meaningful under ent_vld, so it carries no reset.
    always_ff @(posedge in_clk) begin
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (disp_go && (free_idx == IDX_W'(i))) begin
                ent_op[i]       <= in_dispatch_fu_op;
                ent_a_val[i]    <= disp_a_val;
                ent_b_val[i]    <= disp_b_val;
                ent_f_val[i]    <= disp_f_val;
                ent_a_rdy[i]    <= disp_a_rdy;
                ent_b_rdy[i]    <= disp_b_rdy;
                ent_f_rdy[i]    <= disp_f_rdy;
                ent_a_tag[i]    <= in_dispatch_a_rob_index;
                ent_b_tag[i]    <= in_dispatch_b_rob_index;
                ent_f_tag[i]    <= in_dispatch_nzcv_rob_index;
                ent_set_nzcv[i] <= in_dispatch_set_nzcv;
                ent_cond[i]     <= in_dispatch_cond;
                ent_dst[i]      <= in_dispatch_dst_rob_index;
            end else begin
                if (wk_a[i]) begin
                    ent_a_val[i] <= in_cdb_value;
                    ent_a_rdy[i] <= 1'b1;
                end
                if (wk_b[i]) begin
                    ent_b_val[i] <= in_cdb_value;
                    ent_b_rdy[i] <= 1'b1;
                end
                if (wk_f[i]) begin
                    ent_f_val[i] <= in_cdb_nzcv;
                    ent_f_rdy[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed dispatch/broadcast sequences, scoreboard of
// expected issues checked by an independent monitor on the falling edge.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic                    in_clk = 1'b0;
    logic                    in_rst = 1'b0;
    logic                    in_dispatch_valid = 1'b0;
    fu_op_t                  in_dispatch_fu_op = FU_PLUS;
    logic [GPR_SIZE-1:0]     in_dispatch_val_a = '0;
    logic [GPR_SIZE-1:0]     in_dispatch_val_b = '0;
    logic                    in_dispatch_a_ready = 1'b0;
    logic                    in_dispatch_b_ready = 1'b0;
    logic [ROB_IDX_SIZE-1:0] in_dispatch_a_rob_index = '0;
    logic [ROB_IDX_SIZE-1:0] in_dispatch_b_rob_index = '0;
    nzcv_t                   in_dispatch_nzcv = '0;
    logic                    in_dispatch_nzcv_ready = 1'b0;
    logic [ROB_IDX_SIZE-1:0] in_dispatch_nzcv_rob_index = '0;
    logic                    in_dispatch_set_nzcv = 1'b0;
    cond_t                   in_dispatch_cond = '0;
    logic [ROB_IDX_SIZE-1:0] in_dispatch_dst_rob_index = '0;
    logic                    in_cdb_done = 1'b0;
    logic [ROB_IDX_SIZE-1:0] in_cdb_rob_index = '0;
    logic [GPR_SIZE-1:0]     in_cdb_value = '0;
    logic                    in_cdb_set_nzcv = 1'b0;
    nzcv_t                   in_cdb_nzcv = '0;
    logic                    in_fu_ready;
    logic                    in_flush = 1'b0;
    logic                    out_dispatch_ready;
    logic                    out_fu_start;
    fu_op_t                  out_fu_op;
    logic [GPR_SIZE-1:0]     out_fu_val_a;
    logic [GPR_SIZE-1:0]     out_fu_val_b;
    logic [ROB_IDX_SIZE-1:0] out_fu_dst_rob_index;
    logic                    out_fu_set_nzcv;
    nzcv_t                   out_fu_nzcv;
    cond_t                   out_fu_cond;

    // func_units model: ready drops for the cycle following a start.
    logic fu_en = 1'b0;
    assign in_fu_ready = fu_en & ~out_fu_start;

    alu_rs #(.RS_ENTRIES(4)) dut (
        .in_clk(in_clk), .in_rst(in_rst),
        .in_dispatch_valid(in_dispatch_valid), .in_dispatch_fu_op(in_dispatch_fu_op),
        .in_dispatch_val_a(in_dispatch_val_a), .in_dispatch_val_b(in_dispatch_val_b),
        .in_dispatch_a_ready(in_dispatch_a_ready), .in_dispatch_b_ready(in_dispatch_b_ready),
        .in_dispatch_a_rob_index(in_dispatch_a_rob_index),
        .in_dispatch_b_rob_index(in_dispatch_b_rob_index),
        .in_dispatch_nzcv(in_dispatch_nzcv), .in_dispatch_nzcv_ready(in_dispatch_nzcv_ready),
        .in_dispatch_nzcv_rob_index(in_dispatch_nzcv_rob_index),
        .in_dispatch_set_nzcv(in_dispatch_set_nzcv), .in_dispatch_cond(in_dispatch_cond),
        .in_dispatch_dst_rob_index(in_dispatch_dst_rob_index),
        .in_cdb_done(in_cdb_done), .in_cdb_rob_index(in_cdb_rob_index),
        .in_cdb_value(in_cdb_value), .in_cdb_set_nzcv(in_cdb_set_nzcv),
        .in_cdb_nzcv(in_cdb_nzcv), .in_fu_ready(in_fu_ready), .in_flush(in_flush),
        .out_dispatch_ready(out_dispatch_ready), .out_fu_start(out_fu_start),
        .out_fu_op(out_fu_op), .out_fu_val_a(out_fu_val_a), .out_fu_val_b(out_fu_val_b),
        .out_fu_dst_rob_index(out_fu_dst_rob_index), .out_fu_set_nzcv(out_fu_set_nzcv),
        .out_fu_nzcv(out_fu_nzcv), .out_fu_cond(out_fu_cond)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        fu_op_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  dst;
        nzcv_t       f;
        logic        set;
        cond_t       cond;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic push(input fu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] dst, input nzcv_t f, input logic set, input cond_t cond);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.dst = dst; e.f = f; e.set = set; e.cond = cond;
        q.push_back(e);
    endtask

    task automatic disp_set(input fu_op_t op,
                            input logic [31:0] a, input logic ar, input logic [3:0] at,
                            input logic [31:0] b, input logic br, input logic [3:0] bt,
                            input nzcv_t f, input logic fr, input logic [3:0] ft,
                            input logic set, input cond_t cond, input logic [3:0] dst);
        in_dispatch_valid = 1'b1;
        in_dispatch_fu_op = op;
        in_dispatch_val_a = a; in_dispatch_a_ready = ar; in_dispatch_a_rob_index = at;
        in_dispatch_val_b = b; in_dispatch_b_ready = br; in_dispatch_b_rob_index = bt;
        in_dispatch_nzcv = f; in_dispatch_nzcv_ready = fr; in_dispatch_nzcv_rob_index = ft;
        in_dispatch_set_nzcv = set; in_dispatch_cond = cond;
        in_dispatch_dst_rob_index = dst;
    endtask

    task automatic disp_one(input fu_op_t op,
                            input logic [31:0] a, input logic ar, input logic [3:0] at,
                            input logic [31:0] b, input logic br, input logic [3:0] bt,
                            input nzcv_t f, input logic fr, input logic [3:0] ft,
                            input logic set, input cond_t cond, input logic [3:0] dst);
        disp_set(op, a, ar, at, b, br, bt, f, fr, ft, set, cond, dst);
        tick();
        in_dispatch_valid = 1'b0;
    endtask

    task automatic cdb_one(input logic [3:0] tag, input logic [31:0] val,
                           input logic set, input nzcv_t f);
        in_cdb_done = 1'b1; in_cdb_rob_index = tag; in_cdb_value = val;
        in_cdb_set_nzcv = set; in_cdb_nzcv = f;
        tick();
        in_cdb_done = 1'b0; in_cdb_set_nzcv = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 20 && q.size() != 0; k++) tick();
        check(name, q.size(), 0);
    endtask

    // Monitor: every issue strobe must match the oldest outstanding expectation.
    always @(negedge in_clk) begin
        if (!in_rst && out_fu_start) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue actual dst=%0h required=no issue",
                         out_fu_dst_rob_index);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("issue_op",   out_fu_op,            e.op);
                check("issue_a",    out_fu_val_a,         e.a);
                check("issue_b",    out_fu_val_b,         e.b);
                check("issue_dst",  out_fu_dst_rob_index, e.dst);
                check("issue_nzcv", out_fu_nzcv,          e.f);
                check("issue_set",  out_fu_set_nzcv,      e.set);
                check("issue_cond", out_fu_cond,          e.cond);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #1 in_rst = 1'b1;
        #1;
        check("rst_start",    out_fu_start, 0);
        check("rst_dready",   out_dispatch_ready, 1);
        check("rst_val_a",    out_fu_val_a, 0);
        tick(); tick();
        in_rst = 1'b0;
        fu_en  = 1'b1;

        // Ready dispatch: issue strobe one cycle after the dispatch edge
        push(FU_PLUS, 5, 7, 3, 4'b0000, 1'b0, 4'h0);
        disp_one(FU_PLUS, 5, 1, 0, 7, 1, 0, 4'b0000, 1, 0, 1'b0, 4'h0, 3);
        check("ready_not_early", out_fu_start, 0);
        tick();
        check("ready_start", out_fu_start, 1);
        tick();
        check("ready_pulse_end", out_fu_start, 0);
        wait_drain("ready_drain");

        // Wakeup of operand A by broadcast
        push(FU_MINUS, 40, 1, 4, 4'b0000, 1'b0, 4'h0);
        disp_one(FU_MINUS, 0, 0, 2, 1, 1, 0, 4'b0000, 1, 0, 1'b0, 4'h0, 4);
        tick();
        check("wake_waiting", out_fu_start, 0);
        cdb_one(2, 40, 1'b0, 4'b0000);
`ifdef RS_CDB_BYPASS_EN
        check("wake_lat", out_fu_start, 1);
`else
        check("wake_early", out_fu_start, 0);
        tick();
        check("wake_lat", out_fu_start, 1);
`endif
        wait_drain("wake_drain");

        // Full station, ignored 5th dispatch, in-order issue after broadcast
        for (int i = 0; i < 4; i++)
            disp_one(FU_PLUS, 0, 0, 6, i, 1, 0, 4'b0000, 1, 0, 1'b0, 4'h0, 4'(8 + i));
        check("full_dready", out_dispatch_ready, 0);
        disp_one(FU_AND, 1, 1, 0, 2, 1, 0, 4'b0000, 1, 0, 1'b0, 4'h0, 15);
        check("full_still", out_dispatch_ready, 0);
        for (int i = 0; i < 4; i++) push(FU_PLUS, 100, i, 4'(8 + i), 4'b0000, 1'b0, 4'h0);
        cdb_one(6, 100, 1'b0, 4'b0000);
        wait_drain("full_drain");
        tick();
        check("full_dready_back", out_dispatch_ready, 1);

        // Flags: flag-less broadcast must not wake the NZCV operand
        disp_one(FU_CSEL, 3, 1, 0, 9, 1, 0, 4'b0000, 0, 1, 1'b0, 4'h1, 5);
        cdb_one(1, 32'hdead, 1'b0, 4'b1111);
        tick(); tick();
        check("flags_no_wake", out_fu_start, 0);
        push(FU_CSEL, 3, 9, 5, 4'b0100, 1'b0, 4'h1);
        cdb_one(1, 32'hbeef, 1'b1, 4'b0100);
        wait_drain("flags_drain");

        // Flush overrides a same-cycle dispatch
        fu_en = 1'b0;
        tick(); tick();
        for (int i = 0; i < 3; i++)
            disp_one(FU_ORR, i, 1, 0, 1, 1, 0, 4'b0000, 1, 0, 1'b0, 4'h0, 4'(i));
        check("flush_pre_dready", out_dispatch_ready, 1);
        disp_set(FU_EOR, 77, 1, 0, 1, 1, 0, 4'b0000, 1, 0, 1'b0, 4'h0, 12);
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        in_dispatch_valid = 1'b0;
        check("flush_dready", out_dispatch_ready, 1);
        fu_en = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check("flush_no_issue", out_fu_start, 0);

        // Async reset while the start strobe is high
        disp_one(FU_PLUS, 0, 0, 9, 1, 1, 0, 4'b0000, 1, 0, 1'b0, 4'h0, 6);
        disp_one(FU_LSL, 11, 1, 0, 22, 1, 0, 4'b0000, 1, 0, 1'b0, 4'h2, 7);
        tick();
        check("arst_pre_start", out_fu_start, 1);
        check("arst_pre_a",     out_fu_val_a, 11);
        #1 in_rst = 1'b1;
        #1;
        check("arst_start", out_fu_start, 0);
        check("arst_a",     out_fu_val_a, 0);
        check("arst_b",     out_fu_val_b, 0);
        check("arst_dst",   out_fu_dst_rob_index, 0);
        check("arst_cond",  out_fu_cond, 0);
        check("arst_dready", out_dispatch_ready, 1);
        tick();
        in_rst = 1'b0;
        cdb_one(9, 1, 1'b0, 4'b0000);
        for (int k = 0; k < 4; k++) tick();
        check("arst_discarded", out_fu_start, 0);
        check("final_queue", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
